// File: rtl/seg_scan_monitor.sv
// seg_scan_monitor
//   Receive-side monitor for a 6-digit multiplexed 7-segment scanner. It watches the
//   scan lines and debounces each digit dwell. It decodes every stable segment pattern
//   back to a hex nibble and publishes each complete frame as a 24-bit value with
//   decimal points.
//
// Parameters
//   SEL_ACT_LOW  1: sel digit enables are active-low, 0: active-high
//   SEG_ACT_LOW  1: dig segments/dp are active-low,   0: active-high
//   STABLE_CYC   cycles a sel/dig pair must stay unchanged before capture (>=1)
//   TIMEOUT_CYC  cycles without a capture before a partial frame is dropped (>=2)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   sel[5:0]     digit enables, bit i = digit i
//   dig[7:0]     segments a..g on [6:0], dp on [7]
//   value[23:0]  last complete frame, digit i at value[4i+3:4i]
//   dp[5:0]      last complete frame decimal points (1 = lit)
//   frame_valid  one-cycle pulse when value/dp update
//   frame_err    with frame_valid: at least one digit of that frame was undecodable
//   timeout      one-cycle pulse when a partial frame is discarded

module seg_scan_monitor #(
    parameter bit          SEL_ACT_LOW = 1'b1,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter int unsigned STABLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  sel,
    input  logic [7:0]  dig,
    output logic [23:0] value,
    output logic [5:0]  dp,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        timeout
);

    // The stable counter only needs to reach STABLE_CYC-1, the timeout counter TIMEOUT_CYC-1.
    localparam int unsigned StW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam int unsigned ToW = $clog2(TIMEOUT_CYC);
    localparam logic [StW-1:0] StMax = StW'(STABLE_CYC - 1);
    localparam logic [StW-1:0] StOne = StW'(1);
    localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT_CYC - 1);
    localparam logic [ToW-1:0] ToOne = ToW'(1);

    typedef enum logic [1:0] {StIdle, StSettle, StCapture, StHold} state_e;

    // Returns {undecodable, nibble}; patterns are gfedcba with 1 = lit.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h3F:   r = 5'h00;
            7'h06:   r = 5'h01;
            7'h5B:   r = 5'h02;
            7'h4F:   r = 5'h03;
            7'h66:   r = 5'h04;
            7'h6D:   r = 5'h05;
            7'h7D:   r = 5'h06;
            7'h07:   r = 5'h07;
            7'h7F:   r = 5'h08;
            7'h6F:   r = 5'h09;
            7'h77:   r = 5'h0A;
            7'h7C:   r = 5'h0B;
            7'h39:   r = 5'h0C;
            7'h5E:   r = 5'h0D;
            7'h79:   r = 5'h0E;
            7'h71:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    // Input registers (raw polarity) and previous-cycle normalised copy.
    logic [5:0]     sel_q, sel_p_q;
    logic [7:0]     dig_q, dig_p_q;
    logic [StW-1:0] stab_q, stab_d;
    state_e         state_q, state_d;
    logic [23:0]    shadow_q, shadow_d;
    logic [5:0]     shadow_dp_q, shadow_dp_d;
    logic [5:0]     seen_q, seen_d;
    logic           err_q, err_d;
    logic [ToW-1:0] to_q, to_d;
    logic [23:0]    value_q, value_d;
    logic [5:0]     dp_q, dp_d;
    logic           fv_q, fv_d;
    logic           ferr_q, ferr_d;
    logic           tmo_q, tmo_d;

    logic [5:0] sel_n;
    logic [7:0] dig_n;
    logic       onehot;
    logic       dwell;
    logic       capture;
    logic [4:0] dec;
    logic [5:0] seen_nx;
    logic       err_nx;

    assign sel_n  = sel_q ^ {6{SEL_ACT_LOW}};
    assign dig_n  = dig_q ^ {8{SEG_ACT_LOW}};
    assign onehot = (sel_n != 6'd0) && ((sel_n & (sel_n - 6'd1)) == 6'd0);
    assign dwell  = onehot && (sel_n == sel_p_q) && (dig_n == dig_p_q);

    always_comb begin
        stab_d = '0;
        if (dwell) begin
            stab_d = (stab_q == StMax) ? stab_q : stab_q + StOne;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (onehot) state_d = StSettle;
            end
            StSettle: begin
                if (!onehot) begin
                    state_d = StIdle;
                end else if (dwell && (stab_q == StMax)) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                capture = 1'b1;
                // A change landing in the capture cycle itself must still start a new dwell.
                if (!onehot) begin
                    state_d = StIdle;
                end else if (!dwell) begin
                    state_d = StSettle;
                end else begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (!onehot) begin
                    state_d = StIdle;
                end else if (!dwell) begin
                    state_d = StSettle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // In the capture cycle the previous-cycle copy still holds the debounced pair,
    // even if the live lines have just moved on.
    assign dec     = decode(dig_p_q[6:0]);
    assign seen_nx = seen_q | sel_p_q;
    assign err_nx  = err_q | dec[4];

    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        seen_d      = seen_q;
        err_d       = err_q;
        to_d        = to_q;
        value_d     = value_q;
        dp_d        = dp_q;
        fv_d        = 1'b0;
        ferr_d      = ferr_q;
        tmo_d       = 1'b0;
        if (capture) begin
            to_d = '0;
            for (int i = 0; i < 6; i++) begin
                if (sel_p_q[i]) begin
                    shadow_d[4*i +: 4] = dec[3:0];
                    shadow_dp_d[i]     = dig_p_q[7];
                end
            end
            if (seen_nx == 6'h3F) begin
                value_d = shadow_d;
                dp_d    = shadow_dp_d;
                ferr_d  = err_nx;
                fv_d    = 1'b1;
                seen_d  = '0;
                err_d   = 1'b0;
            end else begin
                seen_d = seen_nx;
                err_d  = err_nx;
            end
        end else if (to_q == ToMax) begin
            // With nothing pending the counter just parks at its limit.
            if (seen_q != 6'd0) begin
                seen_d = '0;
                err_d  = 1'b0;
                tmo_d  = 1'b1;
                to_d   = '0;
            end
        end else begin
            to_d = to_q + ToOne;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q       <= {6{SEL_ACT_LOW}};
            dig_q       <= {8{SEG_ACT_LOW}};
            sel_p_q     <= '0;
            dig_p_q     <= '0;
            stab_q      <= '0;
            state_q     <= StIdle;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            seen_q      <= '0;
            err_q       <= 1'b0;
            to_q        <= '0;
            value_q     <= '0;
            dp_q        <= '0;
            fv_q        <= 1'b0;
            ferr_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            sel_q       <= sel;
            dig_q       <= dig;
            sel_p_q     <= sel_n;
            dig_p_q     <= dig_n;
            stab_q      <= stab_d;
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            seen_q      <= seen_d;
            err_q       <= err_d;
            to_q        <= to_d;
            value_q     <= value_d;
            dp_q        <= dp_d;
            fv_q        <= fv_d;
            ferr_q      <= ferr_d;
            tmo_q       <= tmo_d;
        end
    end

    assign value       = value_q;
    assign dp          = dp_q;
    assign frame_valid = fv_q;
    assign frame_err   = ferr_q;
    assign timeout     = tmo_q;

endmodule

// File: tb/tb_seg_scan_monitor.sv
// Directed bench for seg_scan_monitor with active-low scan lines, STABLE_CYC=4 and a
// shortened timeout. Full frames come from a table; dwell, timeout, multi-hot and
// reset corner cases are hand-written sequences.

module tb_seg_scan_monitor;

    localparam int unsigned TO_CYC = 300;

    logic        clk;
    logic        reset;
    logic [5:0]  sel;
    logic [7:0]  dig;
    logic [23:0] value;
    logic [5:0]  dp;
    logic        frame_valid;
    logic        frame_err;
    logic        timeout;

    seg_scan_monitor #(
        .SEL_ACT_LOW (1'b1),
        .SEG_ACT_LOW (1'b1),
        .STABLE_CYC  (4),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sel         (sel),
        .dig         (dig),
        .value       (value),
        .dp          (dp),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Pulse monitor, sampled on the falling edge.
    int          fv_cnt = 0;
    int          to_cnt = 0;
    int          fv_wide = 0;
    logic        fv_prev = 1'b0;
    logic [23:0] cap_value = '0;
    logic [5:0]  cap_dp = '0;
    logic        cap_err = 1'b0;

    always @(negedge clk) begin
        fv_prev <= frame_valid;
        if (frame_valid) begin
            fv_cnt    <= fv_cnt + 1;
            cap_value <= value;
            cap_dp    <= dp;
            cap_err   <= frame_err;
            if (fv_prev) fv_wide <= fv_wide + 1;
        end
        if (timeout) to_cnt <= to_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, required finish before 400000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // act/pat are in 1 = active/lit form; lines are driven active-low.
    task automatic drive(input logic [5:0] act, input logic [7:0] pat, input int n);
        sel = ~act;
        dig = ~pat;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scan_digit(input int i, input logic [7:0] pat, input int n);
        drive(6'(1) << i, pat, n);
    endtask

    task automatic blank(input int n);
        drive(6'h00, 8'h00, n);
    endtask

    typedef struct packed {
        logic [47:0] pats;   // digit i pattern at pats[8i+7:8i]
        logic [23:0] val;
        logic [5:0]  dpv;
        logic        err;
    } frame_t;

    frame_t frames [5];

    logic [47:0] p123456;
    logic [47:0] pabcdef;
    int          base_fv;
    int          base_to;

    initial begin
        frames[0] = '{pats: {8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06},
                      val: 24'h654321, dpv: 6'b000000, err: 1'b0};
        frames[1] = '{pats: {8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77},
                      val: 24'hFEDCBA, dpv: 6'b000000, err: 1'b0};
        frames[2] = '{pats: {8'h79, 8'h07, 8'h49, 8'h7F, 8'h6F, 8'h3F},
                      val: 24'hE70890, dpv: 6'b000000, err: 1'b1};
        frames[3] = '{pats: {8'hFF, 8'h7F, 8'h7F, 8'hFF, 8'h7F, 8'hFF},
                      val: 24'h888888, dpv: 6'b100101, err: 1'b0};
        frames[4] = '{pats: {8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F},
                      val: 24'h000000, dpv: 6'b000000, err: 1'b0};
        p123456 = frames[0].pats;
        pabcdef = frames[1].pats;

        reset = 1'b1;
        sel   = 6'h3F;
        dig   = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_value", 32'(value), 32'h0);
        check("rst_dp", 32'(dp), 32'h0);
        check("rst_fv", 32'(frame_valid), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        reset = 1'b0;
        blank(5);
        check("post_rst_fv_count", 32'(fv_cnt), 32'h0);

        // Table-driven full frames at 8 cycles per digit.
        for (int f = 0; f < 5; f++) begin
            base_fv = fv_cnt;
            for (int i = 0; i < 6; i++) scan_digit(i, frames[f].pats[8*i +: 8], 8);
            blank(6);
            check($sformatf("frame%0d_pulses", f), 32'(fv_cnt - base_fv), 32'h1);
            check($sformatf("frame%0d_value", f), 32'(cap_value), 32'(frames[f].val));
            check($sformatf("frame%0d_dp", f), 32'(cap_dp), 32'(frames[f].dpv));
            check($sformatf("frame%0d_err", f), 32'(cap_err), 32'(frames[f].err));
            check($sformatf("frame%0d_hold", f), 32'(value), 32'(frames[f].val));
        end

        // Short dwell on digit 2 must not capture; the later long dwell completes the frame.
        base_fv = fv_cnt;
        for (int i = 0; i < 6; i++) begin
            if (i != 2) scan_digit(i, p123456[8*i +: 8], 8);
        end
        scan_digit(2, 8'h4F, 3);
        blank(3);
        blank(6);
        check("short_dwell_no_frame", 32'(fv_cnt - base_fv), 32'h0);
        scan_digit(2, 8'h4F, 8);
        blank(6);
        check("redwell_pulses", 32'(fv_cnt - base_fv), 32'h1);
        check("redwell_value", 32'(cap_value), 32'h654321);

        // Long dwell on the last digit, then a partial frame that must time out.
        blank(2);
        base_fv = fv_cnt;
        base_to = to_cnt;
        for (int i = 0; i < 5; i++) scan_digit(i, p123456[8*i +: 8], 8);
        scan_digit(5, p123456[47:40], 40);
        for (int i = 0; i < 5; i++) scan_digit(i, 8'h07, 8);
        blank(6);
        check("long_dwell_pulses", 32'(fv_cnt - base_fv), 32'h1);
        blank(TO_CYC + 50);
        check("timeout_pulse", 32'(to_cnt - base_to), 32'h1);
        check("timeout_no_frame", 32'(fv_cnt - base_fv), 32'h1);
        check("timeout_value_kept", 32'(value), 32'h654321);
        blank(TO_CYC + 50);
        check("timeout_silent_idle", 32'(to_cnt - base_to), 32'h1);
        // Partial frame was dropped: digit 5 alone must not finish a frame.
        scan_digit(5, 8'h07, 8);
        blank(10);
        check("discard_no_frame", 32'(fv_cnt - base_fv), 32'h1);
        blank(TO_CYC + 50);
        check("second_timeout", 32'(to_cnt - base_to), 32'h2);

        // Two digits enabled at once must never be captured.
        base_fv = fv_cnt;
        for (int i = 1; i < 6; i++) scan_digit(i, pabcdef[8*i +: 8], 8);
        drive(6'b000011, 8'h3F, 20);
        blank(10);
        check("multihot_no_frame", 32'(fv_cnt - base_fv), 32'h0);
        scan_digit(0, pabcdef[7:0], 8);
        blank(6);
        check("multihot_then_d0", 32'(fv_cnt - base_fv), 32'h1);
        check("multihot_value", 32'(cap_value), 32'hFEDCBA);

        // Reset in the middle of a frame throws the partial frame away.
        for (int i = 0; i < 3; i++) scan_digit(i, p123456[8*i +: 8], 8);
        base_fv = fv_cnt;
        base_to = to_cnt;
        reset = 1'b1;
        #2;
        check("midrst_value", 32'(value), 32'h0);
        check("midrst_dp", 32'(dp), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        blank(4);
        check("midrst_no_pulse", 32'(to_cnt - base_to), 32'h0);
        for (int i = 3; i < 6; i++) scan_digit(i, pabcdef[8*i +: 8], 8);
        blank(10);
        check("midrst_seen_cleared", 32'(fv_cnt - base_fv), 32'h0);
        for (int i = 0; i < 3; i++) scan_digit(i, pabcdef[8*i +: 8], 8);
        blank(6);
        check("midrst_one_frame", 32'(fv_cnt - base_fv), 32'h1);
        check("midrst_value_after", 32'(cap_value), 32'hFEDCBA);
        check("midrst_err_after", 32'(cap_err), 32'h0);

        check("fv_single_cycle", 32'(fv_wide), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
